axi_lite_slave_mem: RTL and testbench

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

---
 rtl/axi_lite_slave_mem.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI-Lite slave backed by a small register memory
//
// Purpose: word-addressed memory of MEM_WORDS x DATA_WIDTH behind an AXI-Lite
// slave port, with independent write and read state machines and a registered
// LED mirror of word 0.
//
// Ports:
//   S_ACLK, S_ARRESET          clock, asynchronous active-high reset
//   M_AW* / S_AWREADY          write-address channel
//   M_W*  / S_WREADY           write-data channel (with byte strobes)
//   S_B*  / M_BREADY           write-response channel (OKAY / SLVERR)
//   M_AR* / S_ARREADY          read-address channel
//   S_R*  / M_RREADY           read-data channel (OKAY / SLVERR)
//   led                        registered copy of word 0 low LED_WIDTH bits
module axi_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 16,
    parameter int LED_WIDTH  = 16
) (
    input  logic                    S_ACLK,
    input  logic                    S_ARRESET,
    input  logic                    M_AWVALID,
    output logic                    S_AWREADY,
    input  logic [ADDR_WIDTH-1:0]   M_AWADDR,
    input  logic                    M_WVALID,
    output logic                    S_WREADY,
    input  logic [DATA_WIDTH-1:0]   M_WDATA,
    input  logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    S_BVALID,
    input  logic                    M_BREADY,
    output logic [1:0]              S_BRESP,
    input  logic                    M_ARVALID,
    output logic                    S_ARREADY,
    input  logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic                    S_RVALID,
    input  logic                    M_RREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic [LED_WIDTH-1:0]    led
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(MEM_WORDS);
    localparam int IDX_HI     = BYTE_SHIFT + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Address decode: byte-lane bits are dropped, anything above the index
    // field makes the access out of range (no aliasing onto low words).
    logic             aw_ok, ar_ok;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             unused_addr_lsb;
    assign aw_ok  = (M_AWADDR[ADDR_WIDTH-1:IDX_HI] == '0);
    assign ar_ok  = (M_ARADDR[ADDR_WIDTH-1:IDX_HI] == '0);
    assign aw_idx = M_AWADDR[IDX_HI-1:BYTE_SHIFT];
    assign ar_idx = M_ARADDR[IDX_HI-1:BYTE_SHIFT];
    assign unused_addr_lsb = ^{M_AWADDR[BYTE_SHIFT-1:0], M_ARADDR[BYTE_SHIFT-1:0]};

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [LED_WIDTH-1:0]  led_q;

    // Write path state
    logic [1:0]            wstate_q, wstate_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic                  aw_ok_q, aw_ok_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  commit;

    // Read path state
    logic [0:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = M_AWVALID & awready_q;
    assign w_hs  = M_WVALID  & wready_q;
    assign b_hs  = bvalid_q  & M_BREADY;
    assign ar_hs = M_ARVALID & arready_q;
    assign r_hs  = rvalid_q  & M_RREADY;

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_have_d = aw_have_q;
        w_have_d  = w_have_q;
        aw_ok_d   = aw_ok_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                // Raising READY here also covers the first edge after reset.
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs || w_hs) wstate_d = W_WAIT;
            end
            W_WAIT: begin
                if (aw_have_q && w_have_q) begin
                    commit   = 1'b1;
                    bvalid_d = 1'b1;
                    bresp_d  = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        // Each channel is captured independently and its READY stays low
        // until the response handshake.
        if (aw_hs) begin
            aw_have_d = 1'b1;
            awready_d = 1'b0;
            aw_ok_d   = aw_ok;
            awidx_d   = aw_idx;
        end
        if (w_hs) begin
            w_have_d = 1'b1;
            wready_d = 1'b0;
            wdata_d  = M_WDATA;
            wstrb_d  = M_WSTRB;
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    // Memory is sampled on the AR edge, so a write committing
                    // on that same edge is not yet visible.
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = ar_ok ? mem_q[ar_idx] : '0;
                    rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
                    rstate_d  = R_DATA;
                end
            end
            default: begin
                if (r_hs) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge S_ACLK or posedge S_ARRESET) begin
        if (S_ARRESET) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            led_q     <= '0;
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_have_q <= aw_have_d;
            w_have_q  <= w_have_d;
            aw_ok_q   <= aw_ok_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            // Mirrors the committed word 0 one cycle after the commit.
            led_q     <= mem_q[0][LED_WIDTH-1:0];
            if (commit && aw_ok_q) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb_q[b]) mem_q[awidx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_ARREADY = arready_q;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign led       = led_q;
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb/tb_axi_lite_slave_mem.sv - scoreboard bench for axi_lite_slave_mem
module tb_axi_lite_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        M_AWVALID = 1'b0, M_WVALID = 1'b0, M_ARVALID = 1'b0;
    logic        M_BREADY = 1'b1, M_RREADY = 1'b1;
    logic [31:0] M_AWADDR = '0, M_ARADDR = '0, M_WDATA = '0;
    logic [3:0]  M_WSTRB = '0;
    logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
    logic [1:0]  S_BRESP, S_RRESP;
    logic [31:0] S_RDATA;
    logic [15:0] led;

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]  b_exp[$];
    logic [31:0] r_exp_data[$];
    logic [1:0]  r_exp_resp[$];

    always #5 clk = ~clk;

    axi_lite_slave_mem dut (
        .S_ACLK(clk), .S_ARRESET(rst),
        .M_AWVALID(M_AWVALID), .S_AWREADY(S_AWREADY), .M_AWADDR(M_AWADDR),
        .M_WVALID(M_WVALID), .S_WREADY(S_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .S_BVALID(S_BVALID), .M_BREADY(M_BREADY), .S_BRESP(S_BRESP),
        .M_ARVALID(M_ARVALID), .S_ARREADY(S_ARREADY), .M_ARADDR(M_ARADDR),
        .S_RVALID(S_RVALID), .M_RREADY(M_RREADY), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
        .led(led)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected response whenever a handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && S_BVALID && M_BREADY) begin
            if (b_exp.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected: got BVALID with resp %h, expected none", S_BRESP);
            end else chk("bresp", S_BRESP, b_exp.pop_front());
        end
        if (!rst && S_RVALID && M_RREADY) begin
            if (r_exp_data.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL r_unexpected: got RVALID with data %h, expected none", S_RDATA);
            end else begin
                chk("rdata", S_RDATA, r_exp_data.pop_front());
                chk("rresp", S_RRESP, r_exp_resp.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        M_AWVALID = 1'b1; M_AWADDR = a;
        M_WVALID = 1'b1;  M_WDATA = d; M_WSTRB = s;
        b_exp.push_back(resp);
        tick;
        M_AWVALID = 1'b0; M_WVALID = 1'b0;
        chk("awready_drop", S_AWREADY, 1'b0);
        chk("wready_drop", S_WREADY, 1'b0);
        chk("bvalid_early", S_BVALID, 1'b0);
        tick;
        chk("bvalid_latency", S_BVALID, 1'b1);
        for (int i = 0; i < 8 && !S_BVALID; i++) tick;
        tick;
        chk("awready_after_b", S_AWREADY, 1'b1);
        chk("wready_after_b", S_WREADY, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        M_ARVALID = 1'b1; M_ARADDR = a;
        r_exp_data.push_back(d); r_exp_resp.push_back(resp);
        tick;
        M_ARVALID = 1'b0;
        chk("rvalid_latency", S_RVALID, 1'b1);
        chk("arready_drop", S_ARREADY, 1'b0);
        for (int i = 0; i < 8 && !S_RVALID; i++) tick;
        tick;
        chk("arready_after_r", S_ARREADY, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_awready", S_AWREADY, 1'b0);
        chk("rst_arready", S_ARREADY, 1'b0);
        chk("rst_bvalid", S_BVALID, 1'b0);
        chk("rst_rvalid", S_RVALID, 1'b0);
        chk("rst_led", led, 16'h0);
        tick; tick;
        rst = 1'b0;
        chk("post_rst_ready_low", S_AWREADY, 1'b0);
        tick;
        chk("first_edge_awready", S_AWREADY, 1'b1);
        chk("first_edge_wready", S_WREADY, 1'b1);
        chk("first_edge_arready", S_ARREADY, 1'b1);

        // Basic write / read back
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(32'h4, 32'hDEADBEEF, 2'b00);

        // W three cycles before AW, partial strobe to word 0, led mirror
        M_WVALID = 1'b1; M_WDATA = 32'h12345678; M_WSTRB = 4'h3;
        tick;
        M_WVALID = 1'b0;
        chk("w_first_wready", S_WREADY, 1'b0);
        chk("w_first_awready", S_AWREADY, 1'b1);
        tick; tick;
        chk("w_first_no_bvalid", S_BVALID, 1'b0);
        M_AWVALID = 1'b1; M_AWADDR = 32'h0;
        b_exp.push_back(2'b00);
        tick;
        M_AWVALID = 1'b0;
        chk("aw_late_bvalid_early", S_BVALID, 1'b0);
        tick;
        chk("aw_late_bvalid", S_BVALID, 1'b1);
        chk("led_before", led, 16'h0);
        tick;
        chk("led_after", led, 16'h5678);
        do_read(32'h0, 32'h00005678, 2'b00);

        // Out of range, boundary word and unaligned address
        do_write(32'h40, 32'hAAAAAAAA, 4'hF, 2'b10);
        do_read(32'h40, 32'h0, 2'b10);
        do_read(32'h0, 32'h00005678, 2'b00);
        do_read(32'h3C, 32'h0, 2'b00);
        do_write(32'h0B, 32'h11111111, 4'hF, 2'b00);
        do_read(32'h8, 32'h11111111, 2'b00);
        do_write(32'h4, 32'h00AB0000, 4'h4, 2'b00);
        do_read(32'h4, 32'hDEABBEEF, 2'b00);

        // RREADY back-pressure
        M_RREADY = 1'b0;
        M_ARVALID = 1'b1; M_ARADDR = 32'h4;
        r_exp_data.push_back(32'hDEABBEEF); r_exp_resp.push_back(2'b00);
        tick;
        M_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid", S_RVALID, 1'b1);
            chk("hold_rdata", S_RDATA, 32'hDEABBEEF);
            chk("hold_arready", S_ARREADY, 1'b0);
            tick;
        end
        M_RREADY = 1'b1;
        tick;
        chk("arready_after_hold", S_ARREADY, 1'b1);

        // Concurrent read and write of word 2 in the same cycle
        M_AWVALID = 1'b1; M_AWADDR = 32'h8; M_WVALID = 1'b1; M_WDATA = 32'h22222222; M_WSTRB = 4'hF;
        M_ARVALID = 1'b1; M_ARADDR = 32'h8;
        b_exp.push_back(2'b00);
        r_exp_data.push_back(32'h11111111); r_exp_resp.push_back(2'b00);
        tick;
        M_AWVALID = 1'b0; M_WVALID = 1'b0; M_ARVALID = 1'b0;
        chk("conc_rvalid", S_RVALID, 1'b1);
        tick;
        chk("conc_bvalid", S_BVALID, 1'b1);
        chk("conc_arready", S_ARREADY, 1'b1);
        tick;
        do_read(32'h8, 32'h22222222, 2'b00);

        // AR handshake on the very edge the write commits
        M_AWVALID = 1'b1; M_AWADDR = 32'h8; M_WVALID = 1'b1; M_WDATA = 32'h44444444; M_WSTRB = 4'hF;
        b_exp.push_back(2'b00);
        tick;
        M_AWVALID = 1'b0; M_WVALID = 1'b0;
        M_ARVALID = 1'b1; M_ARADDR = 32'h8;
        r_exp_data.push_back(32'h22222222); r_exp_resp.push_back(2'b00);
        tick;
        M_ARVALID = 1'b0;
        chk("rbw_rvalid", S_RVALID, 1'b1);
        chk("rbw_bvalid", S_BVALID, 1'b1);
        tick;
        do_read(32'h8, 32'h44444444, 2'b00);

        // Reset between AW and W handshakes
        M_AWVALID = 1'b1; M_AWADDR = 32'h0;
        tick;
        M_AWVALID = 1'b0;
        chk("abort_awready", S_AWREADY, 1'b0);
        chk("abort_wready", S_WREADY, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_awready", S_AWREADY, 1'b0);
        chk("async_wready", S_WREADY, 1'b0);
        chk("async_arready", S_ARREADY, 1'b0);
        chk("async_rdata", S_RDATA, 32'h0);
        chk("async_led", led, 16'h0);
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("abort_no_bvalid", S_BVALID, 1'b0);
        end
        do_read(32'h0, 32'h0, 2'b00);
        do_read(32'h4, 32'h0, 2'b00);

        tick;
        chk("b_queue_empty", b_exp.size(), 0);
        chk("r_queue_empty", r_exp_data.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
